router_port_arbiter: RTL and testbench
======================================

# router_port_arbiter

Allocates the 16 router output ports among the 16 serial input ports. Each input port frontend decodes a destination address from its frame header and raises a request. This block grants each output to at most one input using per-output round-robin, and holds the grant until end of packet. It drives the crossbar mux selects and the per-input `busy_n` stall back to the testbench/driver side.

## Interface
Parameters:
- `NPORT`, default 16: number of input and output ports.
- `AW`, default 4: port-id width, equal to clog2(`NPORT`).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NPORT  input i holds a decoded header and wants an output; level, held until granted or withdrawn.
- `req_addr`  in  NPORT*AW  destination of input i in slice [i*AW +: AW]; valid while `req[i]`=1.
- `done`  in  NPORT  one-cycle pulse; input i sent its last data bit (frame_n deasserted).
- `grant`  out  NPORT  input i currently owns its destination output.
- `grant_src`  out  NPORT*AW  for output o, the owning input id in slice [o*AW +: AW]; crossbar mux select.
- `out_busy`  out  NPORT  output o is allocated.
- `busy_n`  out  NPORT  active-low; input i is requesting but not granted.

## Operation
- Each output o runs a 2-state FSM: IDLE and OWNED.
- Candidates for o: inputs with `req[i]`=1, `req_addr[i]`==o, and `grant[i]`=0.
- IDLE:
  - If no candidate, stay IDLE.
  - Otherwise pick the first candidate scanning upward from `ptr[o]` with modulo-NPORT wrap.
  - Next state OWNED; set `grant_src[o]`=winner, `grant[winner]`=1, `out_busy[o]`=1, `ptr[o]`=(winner+1) mod NPORT.
- OWNED: leave for IDLE when `done[owner]`=1 or `req[owner]`=0 (abort). On leaving, clear `grant[owner]` and `out_busy[o]`. `grant_src[o]` holds its last value.
- No same-cycle handoff: a freed output is arbitrated only after it is back in IDLE.
- `req_addr[i]` changes while input i is granted are ignored; ownership is tied to the registered `grant_src`.
- `done[i]` when input i is not granted is ignored.
- `req[i]` withdrawn while ungranted: input i drops out of arbitration with no side effects.
- `done[i]` and a new `req[i]` in the same cycle: release happens first; input i competes normally from the following cycle.
- `busy_n[i]` (registered) is loaded with ~(`req[i]` & ~next `grant[i]`).
- An input owns at most one output at a time (single destination); different outputs grant independently and in parallel.

## Timing
- Reset values:
  - `grant`=0, `out_busy`=0, `grant_src`=0.
  - `busy_n`='1 (all ones).
  - All FSMs IDLE, all `ptr`=0.
  - All values apply immediately on `reset` assertion, asynchronously.
- Request latency: `req` sampled at edge N gives `grant`/`out_busy`/`grant_src` valid after edge N; `busy_n` stays 1 for the winner.
- Release: `done` sampled at edge K clears the grant after edge K. The next waiting candidate is granted after edge K+1, a 1-cycle bubble.
- `busy_n[i]` falls after the first edge at which input i is requesting and loses arbitration. It rises with the edge that grants input i or sees `req[i]`=0.
- Reset mid-packet: all grants drop and all pointers return to 0. Inputs still requesting re-arbitrate from the first edge after `reset` deasserts.

## Structure
- `router_pkg` holds:
  - `NPORT`, `AW`
  - `typedef logic [AW-1:0] port_id_t`
  - `typedef enum logic {IDLE, OWNED} out_state_e`
- Sub-module `rr_arbiter` covers one output's FSM, pointer, and owner register. It is instantiated NPORT times in a generate loop.
- The top level builds per-output candidate vectors, ORs per-output grants into `grant`, and registers `busy_n`.

## Test plan
- Reset: assert `reset` mid-simulation → `grant`=16'h0000, `busy_n`=16'hFFFF, `out_busy`=0 in the same cycle.
- Single request: `req[3]`=1, addr 7 → after one edge `grant[3]`=1, `out_busy[7]`=1, `grant_src[7]`=3, `busy_n[3]`=1.
- Contention and round-robin on output 4, starting with `ptr[4]`=0:
  - Inputs 2, 5, 9 request output 4 together → input 2 granted; `busy_n[5]`=`busy_n[9]`=0.
  - `done[2]` → input 5 granted 2 edges later; after `done[5]`, input 9 granted.
  - Final `ptr[4]`=10.
- Full permutation: input i → output 15-i for all i simultaneously → all 16 grants after one edge, `grant_src[o]`=15-o, `busy_n`=16'hFFFF.
- Abort: granted input 5 drops `req` without `done` → `out_busy` cleared after the next edge; a waiting input 6 is granted one edge after that.
- Stray `done`/address change: `done[8]` while input 8 is ungranted → no effect; owner changes `req_addr` mid-packet → `grant_src` unchanged.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and sizing for the router output-port arbiter.
// Port count, port-id width and the per-output allocation state.
package router_pkg;

    localparam int NPORT = 16;
    localparam int AW    = 4;

    typedef logic [AW-1:0] port_id_t;

    typedef enum logic {
        IDLE,
        OWNED
    } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// One output port: round-robin pick among candidates, hold until
// the owner signals end of packet or withdraws its request.
module rr_arbiter #(
    parameter int NPORT = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPORT-1:0] cand,
    input  logic [NPORT-1:0] req,
    input  logic [NPORT-1:0] done,
    output logic             busy,
    output logic [AW-1:0]    owner,
    output logic [NPORT-1:0] grant_cur,
    output logic [NPORT-1:0] grant_nxt
);

    import router_pkg::*;

    out_state_e    state;
    out_state_e    state_nxt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_nxt;
    logic [AW-1:0] owner_nxt;
    logic [AW-1:0] win;
    logic [AW-1:0] idx;
    logic          found;

    // First candidate at or above ptr, wrapping modulo NPORT.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = '0;
        for (int k = 0; k < NPORT; k++) begin
            idx = AW'((int'(ptr) + k) % NPORT);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OWNED;
                    owner_nxt = win;
                    ptr_nxt   = AW'((int'(win) + 1) % NPORT);
                end
            end
            OWNED: begin
                if (done[owner] || !req[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        grant_cur = '0;
        grant_nxt = '0;
        if (state == OWNED) begin
            grant_cur[owner] = 1'b1;
        end
        if (state_nxt == OWNED) begin
            grant_nxt[owner_nxt] = 1'b1;
        end
    end

    assign busy = (state == OWNED);

endmodule

// File: rtl/router_port_arbiter.sv
// Allocates router outputs to inputs: per-output round-robin,
// crossbar selects, and the registered per-input stall.
module router_port_arbiter #(
    parameter int NPORT = 16,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT*AW-1:0] req_addr,
    input  logic [NPORT-1:0]    done,
    output logic [NPORT-1:0]    grant,
    output logic [NPORT*AW-1:0] grant_src,
    output logic [NPORT-1:0]    out_busy,
    output logic [NPORT-1:0]    busy_n
);

    import router_pkg::*;

    logic [NPORT-1:0] cand      [NPORT];
    logic [NPORT-1:0] grant_cur [NPORT];
    logic [NPORT-1:0] grant_nxt [NPORT];
    logic [NPORT-1:0] next_grant;

    // Inputs already holding an output never compete for another one.
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            cand[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                cand[o][i] = req[i]
                           && (req_addr[i*AW +: AW] == AW'(o))
                           && !grant[i];
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        rr_arbiter #(
            .NPORT (NPORT),
            .AW    (AW)
        ) u_arb (
            .clk       (clk),
            .reset     (reset),
            .cand      (cand[o]),
            .req       (req),
            .done      (done),
            .busy      (out_busy[o]),
            .owner     (grant_src[o*AW +: AW]),
            .grant_cur (grant_cur[o]),
            .grant_nxt (grant_nxt[o])
        );
    end

    always_comb begin
        grant      = '0;
        next_grant = '0;
        for (int o = 0; o < NPORT; o++) begin
            grant      = grant | grant_cur[o];
            next_grant = next_grant | grant_nxt[o];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_n <= '1;
        end else begin
            busy_n <= ~(req & ~next_grant);
        end
    end

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed and random stimulus for router_port_arbiter against an
// ownership-table reference model.
module tb_router_port_arbiter;

    localparam int NPORT = 16;
    localparam int AW    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NPORT-1:0]    req;
    logic [NPORT*AW-1:0] req_addr;
    logic [NPORT-1:0]    done;
    logic [NPORT-1:0]    grant;
    logic [NPORT*AW-1:0] grant_src;
    logic [NPORT-1:0]    out_busy;
    logic [NPORT-1:0]    busy_n;

    router_port_arbiter #(
        .NPORT (NPORT),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .done      (done),
        .grant     (grant),
        .grant_src (grant_src),
        .out_busy  (out_busy),
        .busy_n    (busy_n)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: which input owns each output (-1 = free), rr pointers,
    // last owner per output, and the expected stall vector.
    int                  own  [NPORT];
    int                  mptr [NPORT];
    logic [NPORT*AW-1:0] msrc;
    logic [NPORT-1:0]    mbusy_n;

    function automatic int addr_of(input int i);
        return int'(req_addr[i*AW +: AW]);
    endfunction

    function automatic logic [NPORT-1:0] mgrant();
        logic [NPORT-1:0] g;
        g = '0;
        for (int o = 0; o < NPORT; o++)
            if (own[o] >= 0) g[own[o]] = 1'b1;
        return g;
    endfunction

    function automatic logic [NPORT-1:0] mout_busy();
        logic [NPORT-1:0] b;
        b = '0;
        for (int o = 0; o < NPORT; o++) b[o] = (own[o] >= 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NPORT; o++) begin
            own[o]  = -1;
            mptr[o] = 0;
        end
        msrc    = '0;
        mbusy_n = '1;
    endtask

    task automatic model_step();
        logic [NPORT-1:0] g;
        int               nown [NPORT];
        int               c;
        bit               found;
        g = mgrant();
        for (int o = 0; o < NPORT; o++) nown[o] = own[o];
        for (int o = 0; o < NPORT; o++) begin
            if (own[o] >= 0) begin
                if (done[own[o]] || !req[own[o]]) nown[o] = -1;
            end else begin
                found = 0;
                for (int k = 0; k < NPORT; k++) begin
                    c = (mptr[o] + k) % NPORT;
                    if (!found && req[c] && addr_of(c) == o && !g[c]) begin
                        found   = 1;
                        nown[o] = c;
                        mptr[o] = (c + 1) % NPORT;
                        msrc[o*AW +: AW] = AW'(c);
                    end
                end
            end
        end
        for (int o = 0; o < NPORT; o++) own[o] = nown[o];
        g       = mgrant();
        mbusy_n = ~(req & ~g);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".grant"}, grant, mgrant());
        chk({tag, ".out_busy"}, out_busy, mout_busy());
        chk({tag, ".busy_n"}, busy_n, mbusy_n);
        chk({tag, ".grant_src"}, grant_src, msrc);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_req(input int i, input int a);
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = AW'(a);
    endtask

    logic [NPORT*AW-1:0] exp_src;
    logic [NPORT-1:0]    gnow;

    initial begin
        reset    = 1'b1;
        req      = '0;
        done     = '0;
        req_addr = '0;
        model_reset();
        #1;
        check_all("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick("idle");

        set_req(3, 7);
        tick("single");
        chk("single.grant3", grant[3], 1);
        chk("single.busy7", out_busy[7], 1);
        chk("single.src7", grant_src[7*AW +: AW], 3);
        chk("single.busy_n3", busy_n[3], 1);
        done[3] = 1'b1;
        req[3]  = 1'b0;
        tick("single.rel");
        done = '0;
        chk("single.rel.g3", grant[3], 0);

        set_req(2, 4);
        set_req(5, 4);
        set_req(9, 4);
        tick("cont");
        chk("cont.g2", grant[2], 1);
        chk("cont.g5", grant[5], 0);
        chk("cont.bn5", busy_n[5], 0);
        chk("cont.bn9", busy_n[9], 0);
        done[2] = 1'b1;
        req[2]  = 1'b0;
        tick("cont.rel2");
        done = '0;
        chk("cont.bubble", out_busy[4], 0);
        tick("cont.g5");
        chk("cont.g5b", grant[5], 1);
        chk("cont.src5", grant_src[4*AW +: AW], 5);
        done[5] = 1'b1;
        req[5]  = 1'b0;
        tick("cont.rel5");
        done = '0;
        tick("cont.g9");
        chk("cont.g9b", grant[9], 1);
        done[9] = 1'b1;
        req[9]  = 1'b0;
        tick("cont.rel9");
        done = '0;
        set_req(3, 4);
        set_req(11, 4);
        tick("rr.ptr10");
        chk("rr.ptr10.g11", grant[11], 1);
        chk("rr.ptr10.g3", grant[3], 0);
        done[11] = 1'b1;
        req      = '0;
        tick("rr.rel");
        done = '0;
        tick("rr.quiet");

        for (int i = 0; i < NPORT; i++) set_req(i, 15 - i);
        tick("perm");
        chk("perm.grant", grant, 16'hFFFF);
        chk("perm.busy_n", busy_n, 16'hFFFF);
        for (int o = 0; o < NPORT; o++) exp_src[o*AW +: AW] = AW'(15 - o);
        chk("perm.src", grant_src, exp_src);
        done = '1;
        req  = '0;
        tick("perm.rel");
        done = '0;
        chk("perm.rel.busy", out_busy, 16'h0000);

        set_req(5, 0);
        set_req(6, 0);
        tick("abort");
        chk("abort.g5", grant[5], 1);
        chk("abort.bn6", busy_n[6], 0);
        req[5] = 1'b0;
        tick("abort.drop");
        chk("abort.free", out_busy[0], 0);
        chk("abort.g6", grant[6], 0);
        tick("abort.g6");
        chk("abort.g6b", grant[6], 1);
        chk("abort.src0", grant_src[0 +: AW], 6);

        done[8] = 1'b1;
        tick("stray");
        done = '0;
        chk("stray.busy", out_busy, 16'h0001);
        req_addr[6*AW +: AW] = 4'd9;
        tick("addrchg");
        chk("addrchg.src0", grant_src[0 +: AW], 6);
        chk("addrchg.busy9", out_busy[9], 0);

        set_req(1, 2);
        tick("pre_rst");
        #3;
        reset = 1'b1;
        #1;
        chk("rst.grant", grant, 16'h0000);
        chk("rst.busy_n", busy_n, 16'hFFFF);
        chk("rst.out_busy", out_busy, 16'h0000);
        chk("rst.src", grant_src, 64'h0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick("post_rst");
        chk("post_rst.g6", grant[6], 1);
        chk("post_rst.g1", grant[1], 1);
        req = '0;
        tick("post_rst.clr");

        repeat (500) begin
            gnow = mgrant();
            for (int i = 0; i < NPORT; i++) begin
                if (gnow[i]) begin
                    case ($urandom_range(0, 11))
                        0: begin
                            done[i] = 1'b1;
                            req[i]  = 1'($urandom_range(0, 1));
                            req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                        end
                        1: req[i] = 1'b0;
                        2: req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                        default: ;
                    endcase
                end else if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                    if ($urandom_range(0, 30) == 0) done[i] = 1'b1;
                end else if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        set_req(i, $urandom_range(0, 3));
                    else
                        set_req(i, $urandom_range(0, 15));
                end
            end
            tick("rand");
            done = '0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
